chunked_adder: RTL and testbench

CHUNKED_ADDER -- requirements
Module: chunked_adder

---
 rtl/chunked_adder.sv | 129 ++++++++++++
 tb/tb_chunked_adder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor: CHUNK bits of the result are computed per cycle,
// LSB slice first. Requests and results each use a valid/ready handshake.
module chunked_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;
    logic [IDXW-1:0]   idx_q, idx_d;

    logic [CHUNK-1:0]  a_slice [NCHUNK];
    logic [CHUNK-1:0]  b_slice [NCHUNK];
    logic [CHUNK:0]    chunk_sum;
    logic              last_chunk;

    genvar gi;
    generate
        for (gi = 0; gi < NCHUNK; gi++) begin : g_slice
            assign a_slice[gi] = a_q[gi*CHUNK +: CHUNK];
            assign b_slice[gi] = b_q[gi*CHUNK +: CHUNK];
        end
    endgenerate

    // b_q already holds B' (inverted for subtract), so one adder serves both ops.
    assign chunk_sum  = {1'b0, a_slice[idx_q]} + {1'b0, b_slice[idx_q]}
                      + {{CHUNK{1'b0}}, carry_q};
    assign last_chunk = (idx_q == IDXW'(NCHUNK - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = cin ^ sub;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < NCHUNK; i++) begin
                    if (idx_q == IDXW'(i)) begin
                        sum_d[i*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
                    end
                end
                carry_d = chunk_sum[CHUNK];
                idx_d   = idx_q + 1'b1;
                if (last_chunk) begin
                    cout_d  = chunk_sum[CHUNK];
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                              (chunk_sum[CHUNK-1] != a_q[WIDTH-1]);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            idx_q   <= idx_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_chunked_adder.sv
// Scoreboard bench for chunked_adder: directed 16/4 cases plus an exhaustive 4/2 sweep.
module tb_chunked_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, cin, sub, out_ready;
    logic [15:0] a, b;
    logic        in_ready, out_valid, cout, ovf;
    logic [15:0] sum;

    logic        s_start, s_cin, s_sub, s_out_ready;
    logic [3:0]  s_a, s_b;
    logic        s_in_ready, s_out_valid, s_cout, s_ovf;
    logic [3:0]  s_sum;

    int checks = 0;
    int errors = 0;

    // Packed expectation: [17]=ovf, [16]=cout, [15:0]=sum
    logic [17:0] exp_q [$];
    logic [17:0] s_exp_q [$];

    always #5 clk = ~clk;

    chunked_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .start(start), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    chunked_adder #(.WIDTH(4), .CHUNK(2)) dut_small (
        .clk(clk), .rst(rst), .start(s_start), .in_ready(s_in_ready),
        .a(s_a), .b(s_b), .cin(s_cin), .sub(s_sub),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .sum(s_sum), .cout(s_cout), .ovf(s_ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Arithmetic reference: plain integer math, no chunking.
    function automatic logic [17:0] model(input int w, input int ua, input int ub,
                                          input bit c, input bit s);
        int res, sa, sb, sres, full, half;
        logic [17:0] r;
        full = 1 << w;
        half = 1 << (w - 1);
        res  = s ? (ua - ub - int'(c)) : (ua + ub + int'(c));
        sa   = (ua >= half) ? ua - full : ua;
        sb   = (ub >= half) ? ub - full : ub;
        sres = s ? (sa - sb - int'(c)) : (sa + sb + int'(c));
        r        = '0;
        r[15:0]  = 16'(res & (full - 1));
        r[16]    = s ? (res >= 0) : (res >= full);
        r[17]    = (sres < -half) || (sres >= half);
        return r;
    endfunction

    task automatic take_result();
        logic [17:0] e;
        out_ready = 1'b1;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
        check("result", {14'd0, ovf, cout, sum}, {14'd0, e});
        $display("op16 -> sum=%h cout=%0b ovf=%0b (exp sum=%h cout=%0b ovf=%0b)",
                 sum, cout, ovf, e[15:0], e[16], e[17]);
        @(negedge clk);
        out_ready = 1'b0;
        check("idle_after_handoff", {30'd0, in_ready, out_valid}, 32'd2);
        check("retain_after_handoff", {14'd0, ovf, cout, sum}, {14'd0, e});
    endtask

    task automatic accept_op(input logic [15:0] ta, input logic [15:0] tb_v,
                             input logic tc, input logic ts);
        int cyc;
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        a = ta; b = tb_v; cin = tc; sub = ts; start = 1'b1;
        exp_q.push_back(model(16, int'(ta), int'(tb_v), tc, ts));
        @(negedge clk);
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("latency16", cyc, 32'd4);
    endtask

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic tc, input logic ts);
        accept_op(ta, tb_v, tc, ts);
        take_result();
    endtask

    task automatic small_op(input logic [3:0] ta, input logic [3:0] tb_v,
                            input logic tc, input logic ts);
        int cyc;
        logic [17:0] e;
        check("s_in_ready_idle", {31'd0, s_in_ready}, 32'd1);
        s_a = ta; s_b = tb_v; s_cin = tc; s_sub = ts; s_start = 1'b1;
        s_exp_q.push_back(model(4, int'(ta), int'(tb_v), tc, ts));
        @(negedge clk);
        s_start = 1'b0;
        s_a = 4'($urandom); s_b = 4'($urandom);
        cyc = 0;
        while (!s_out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("latency4", cyc, 32'd2);
        s_out_ready = 1'b1;
        e = (s_exp_q.size() != 0) ? s_exp_q.pop_front() : 18'h3ffff;
        check("s_result", {26'd0, s_ovf, s_cout, s_sum}, {26'd0, e[17], e[16], e[3:0]});
        $display("op4 a=%h b=%h cin=%0b sub=%0b -> sum=%h cout=%0b ovf=%0b",
                 ta, tb_v, tc, ts, s_sum, s_cout, s_ovf);
        @(negedge clk);
        s_out_ready = 1'b0;
    endtask

    initial begin
        logic [17:0] e;
        logic [9:0]  v;
        rst = 1'b1;
        start = 0; a = 0; b = 0; cin = 0; sub = 0; out_ready = 0;
        s_start = 0; s_a = 0; s_b = 0; s_cin = 0; s_sub = 0; s_out_ready = 0;
        #2;
        check("reset_outputs", {14'd0, ovf, cout, sum}, 32'd0);
        check("reset_handshake", {30'd0, in_ready, out_valid}, 32'd2);
        check("s_reset_outputs", {24'd0, s_in_ready, s_out_valid, s_ovf, s_cout, s_sum}, 32'h80);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1);
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1);
        run_op(16'h1234, 16'hABCD, 1'b1, 1'b0);
        run_op(16'h0000, 16'h0000, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        end

        // Backpressure: result must stay put and a start pulse must be dropped.
        accept_op(16'h4321, 16'h1111, 1'b0, 1'b1);
        e = exp_q[0];
        for (int i = 0; i < 10; i++) begin
            start = (i % 3 == 0);
            a = 16'($urandom); b = 16'($urandom);
            @(negedge clk);
            check("bp_valid_ready", {30'd0, out_valid, in_ready}, 32'd2);
            check("bp_stable", {14'd0, ovf, cout, sum}, {14'd0, e});
        end
        start = 1'b0;
        take_result();
        @(negedge clk);
        check("bp_no_ghost_op", {31'd0, out_valid}, 32'd0);

        // Reset in the second RUN cycle aborts the operation.
        a = 16'h1234; b = 16'h1111; cin = 0; sub = 0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_outputs", {14'd0, ovf, cout, sum}, 32'd0);
        check("abort_handshake", {30'd0, in_ready, out_valid}, 32'd2);
        @(negedge clk);
        check("abort_no_valid", {31'd0, out_valid}, 32'd0);
        rst = 1'b0;
        run_op(16'h0001, 16'h0002, 1'b0, 1'b0);

        for (int i = 0; i < 1024; i++) begin
            v = 10'(i);
            small_op(v[3:0], v[7:4], v[8], v[9]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got 0x0 expected 0x1");
        $fatal(1, "timeout");
    end

endmodule
